mul_div_unit: RTL



---
 rtl/mul_div_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed multiply / restoring divide unit.
// MUL leaves the full 2*WIDTH product in zhigh:zlow; DIV leaves the quotient
// in zlow and the remainder in zhigh.
// Optional feature macro MULDIV_EARLY_ZERO_EN: when defined, a zero operand
// (MUL with a or b zero, DIV with a zero and b nonzero) skips the iteration
// phase. When undefined, those cases run the full loop and give the same values.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] zhigh,
  output logic [WIDTH-1:0] zlow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, FINISH} state_t;

  state_t               state_reg, state_next;
  logic                 op_reg;
  logic [WIDTH-1:0]     a_reg, b_reg, mcand_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        count_reg;
  logic                 neg_lo_reg;   // product sign / quotient sign
  logic                 neg_hi_reg;   // remainder sign (follows dividend)

  logic                 b_zero, skip_iter;
  logic [WIDTH-1:0]     mag_a, mag_b, quo, rem;
  logic [WIDTH:0]       add_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0]   mul_step, div_step;

  assign b_zero = (b_reg == '0);

`ifdef MULDIV_EARLY_ZERO_EN
  assign skip_iter = b_zero || (a_reg == '0);
`else
  assign skip_iter = op_reg && b_zero;
`endif

  // Operand magnitudes; the most-negative value maps to itself, which reads
  // correctly as an unsigned magnitude.
  assign mag_a = a_reg[WIDTH-1] ? ('0 - a_reg) : a_reg;
  assign mag_b = b_reg[WIDTH-1] ? ('0 - b_reg) : b_reg;

  // Shift-add step: multiplier sits in the low half and shifts out LSB first.
  assign add_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg};
  assign mul_step = acc_reg[0] ? {add_sum, acc_reg[WIDTH-1:1]}
                               : {1'b0, acc_reg[2*WIDTH-1:1]};

  // Restoring step: partial remainder in the high half, dividend shifting out
  // of the low half while quotient bits shift in.
  assign rem_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign rem_diff  = rem_shift - {1'b0, mcand_reg};
  assign div_step  = rem_diff[WIDTH]
                   ? {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                   : {rem_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

  assign quo  = acc_reg[WIDTH-1:0];
  assign rem  = acc_reg[2*WIDTH-1:WIDTH];
  assign busy = (state_reg != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = skip_iter ? FINISH : ITER;
      ITER:    if (count_reg == CW'(WIDTH - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result write.
  always_ff @(posedge clk) begin
    if (clr) begin
      op_reg      <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      neg_lo_reg  <= 1'b0;
      neg_hi_reg  <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      zhigh       <= '0;
      zlow        <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg      <= op;
            a_reg       <= a;
            b_reg       <= b;
            div_by_zero <= 1'b0;
          end
        end
        LOAD: begin
          count_reg  <= '0;
          mcand_reg  <= mag_b;
          neg_lo_reg <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          neg_hi_reg <= a_reg[WIDTH-1];
          acc_reg    <= skip_iter ? '0 : {{WIDTH{1'b0}}, mag_a};
        end
        ITER: begin
          acc_reg   <= op_reg ? div_step : mul_step;
          count_reg <= count_reg + 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          if (op_reg && b_zero) begin
            zlow        <= '1;
            zhigh       <= a_reg;
            div_by_zero <= 1'b1;
          end else if (op_reg) begin
            zlow  <= neg_lo_reg ? ('0 - quo) : quo;
            zhigh <= neg_hi_reg ? ('0 - rem) : rem;
          end else begin
            {zhigh, zlow} <= neg_lo_reg ? ('0 - acc_reg) : acc_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
